node_link_transmitter: RTL and testbench

NODE_LINK_TRANSMITTER -- requirements
Module: node_link_transmitter

---
 rtl/node_link_transmitter.sv | 111 +++++++++++
 tb/tb_node_link_transmitter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/node_link_transmitter.sv
// Word transmitter: queues 32-bit words in a small FIFO and strobes them out
// one at a time, each strobe followed by a fixed idle gap.
module node_link_transmitter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 8
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [31:0] wrData,
   input  logic        wrEn,
   output logic        full,
   output logic        overflow,
   output logic [31:0] shiftOutData,
   output logic        shiftOutCS,
   output logic        busy,
   output logic [7:0]  sentCount
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    gap_cnt;
   logic          push, pop, load_gap;

   // Full is evaluated before any same-cycle pop, so a write into a full FIFO is always dropped.
   assign full = (count == (AW+1)'(DEPTH));
   assign push = wrEn && !full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wrData;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (wrEn && full) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (count != '0) state_nxt = S_SEND;
         S_SEND: state_nxt = S_GAP;
         S_GAP:  if (gap_cnt == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pop        = (state == S_IDLE) && (count != '0);
      load_gap   = (state == S_SEND);
      shiftOutCS = (state == S_SEND);
      busy       = (state != S_IDLE) || (count != '0);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shiftOutData <= '0;
         sentCount    <= '0;
         gap_cnt      <= '0;
      end else begin
         if (pop) begin
            shiftOutData <= mem[rd_ptr];
            sentCount    <= sentCount + 8'd1;
         end
         if (load_gap) begin
            gap_cnt <= 8'(GAP - 1);
         end else if ((state == S_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_node_link_transmitter.sv
// Directed bench for node_link_transmitter with DEPTH=4, GAP=8.
module tb_node_link_transmitter;

   logic        clk;
   logic        resetN;
   logic [31:0] wrData;
   logic        wrEn;
   logic        full;
   logic        overflow;
   logic [31:0] shiftOutData;
   logic        shiftOutCS;
   logic        busy;
   logic [7:0]  sentCount;

   int checks = 0;
   int errors = 0;

   node_link_transmitter #(.DEPTH(4), .GAP(8)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .wrData       (wrData),
      .wrEn         (wrEn),
      .full         (full),
      .overflow     (overflow),
      .shiftOutData (shiftOutData),
      .shiftOutCS   (shiftOutCS),
      .busy         (busy),
      .sentCount    (sentCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] wd;
      logic        cs;
      logic [31:0] data;
      logic        full;
      logic        busy;
      logic [7:0]  sent;
      logic        ovf;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int          ns;
      int          n;
      int          extra;
      int          wi;
      int          ri;
      bit          found;
      logic [31:0] burst_exp [3];

      // Single word, then four words queued during the gap plus two writes that hit a full FIFO.
      tbl[0]  = '{1'b1, 32'hC400_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'd0, 1'b0};
      tbl[1]  = '{1'b0, 32'h0000_0000, 1'b1, 32'hC400_0000, 1'b0, 1'b1, 8'd1, 1'b0};
      tbl[2]  = '{1'b0, 32'h0000_0000, 1'b0, 32'hC400_0000, 1'b0, 1'b1, 8'd1, 1'b0};
      tbl[3]  = '{1'b1, 32'h0000_0049, 1'b0, 32'hC400_0000, 1'b0, 1'b1, 8'd1, 1'b0};
      tbl[4]  = '{1'b1, 32'hC400_0000, 1'b0, 32'hC400_0000, 1'b0, 1'b1, 8'd1, 1'b0};
      tbl[5]  = '{1'b1, 32'h0400_0000, 1'b0, 32'hC400_0000, 1'b0, 1'b1, 8'd1, 1'b0};
      tbl[6]  = '{1'b1, 32'h8000_0000, 1'b0, 32'hC400_0000, 1'b1, 1'b1, 8'd1, 1'b0};
      tbl[7]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 32'hC400_0000, 1'b1, 1'b1, 8'd1, 1'b1};
      tbl[8]  = '{1'b0, 32'h0000_0000, 1'b0, 32'hC400_0000, 1'b1, 1'b1, 8'd1, 1'b1};
      tbl[9]  = '{1'b0, 32'h0000_0000, 1'b0, 32'hC400_0000, 1'b1, 1'b1, 8'd1, 1'b1};
      tbl[10] = '{1'b0, 32'h0000_0000, 1'b0, 32'hC400_0000, 1'b1, 1'b1, 8'd1, 1'b1};
      tbl[11] = '{1'b1, 32'h1111_1111, 1'b1, 32'h0000_0049, 1'b0, 1'b1, 8'd2, 1'b1};
      tbl[12] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0049, 1'b0, 1'b1, 8'd2, 1'b1};
      burst_exp[0] = 32'hC400_0000;
      burst_exp[1] = 32'h0400_0000;
      burst_exp[2] = 32'h8000_0000;

      resetN = 1'b0;
      wrEn   = 1'b0;
      wrData = '0;
      repeat (2) tick();
      chk("rst_cs",   32'(shiftOutCS),   32'd0);
      chk("rst_data", shiftOutData,      32'd0);
      chk("rst_full", 32'(full),         32'd0);
      chk("rst_ovf",  32'(overflow),     32'd0);
      chk("rst_sent", 32'(sentCount),    32'd0);
      chk("rst_busy", 32'(busy),         32'd0);
      @(negedge clk);
      resetN = 1'b1;

      for (int i = 0; i < 13; i++) begin
         wrEn   = tbl[i].we;
         wrData = tbl[i].wd;
         tick();
         wrEn = 1'b0;
         chk($sformatf("vec%0d_cs", i),   32'(shiftOutCS), 32'(tbl[i].cs));
         chk($sformatf("vec%0d_data", i), shiftOutData,    tbl[i].data);
         chk($sformatf("vec%0d_full", i), 32'(full),       32'(tbl[i].full));
         chk($sformatf("vec%0d_busy", i), 32'(busy),       32'(tbl[i].busy));
         chk($sformatf("vec%0d_sent", i), 32'(sentCount),  32'(tbl[i].sent));
         chk($sformatf("vec%0d_ovf", i),  32'(overflow),   32'(tbl[i].ovf));
      end

      // Remaining burst strobes every GAP+2 cycles, counted from the 0x49 strobe.
      ns = 0;
      for (int c = 2; c <= 60 && ns < 3; c++) begin
         tick();
         if (shiftOutCS) begin
            chk("burst_data", shiftOutData, burst_exp[ns]);
            chk("burst_time", 32'(c), 32'(10 * (ns + 1)));
            ns++;
         end
      end
      chk("burst_strobes", 32'(ns), 32'd3);
      repeat (8) tick();
      chk("busy_before_idle", 32'(busy), 32'd1);
      tick();
      chk("busy_after_gap", 32'(busy), 32'd0);
      extra = 0;
      repeat (20) begin
         tick();
         if (shiftOutCS) extra++;
      end
      chk("no_dropped_strobe", 32'(extra), 32'd0);
      chk("burst_sent", 32'(sentCount), 32'd5);
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Write three cycles into GAP must wait for the normal strobe period.
      wrEn = 1'b1; wrData = 32'h1234_5678;
      tick();
      wrEn = 1'b0;
      tick();
      chk("gapw_first_cs", 32'(shiftOutCS), 32'd1);
      n = 0;
      repeat (3) begin
         tick();
         n++;
      end
      wrEn = 1'b1; wrData = 32'h4000_0000;
      tick();
      n++;
      wrEn  = 1'b0;
      found = 1'b0;
      while (n < 30 && !found) begin
         tick();
         n++;
         if (shiftOutCS) found = 1'b1;
      end
      chk("gapw_period", 32'(n), 32'd10);
      chk("gapw_data", shiftOutData, 32'h4000_0000);

      // Reset asserted during a strobe with two words still queued.
      repeat (12) tick();
      wrEn = 1'b1; wrData = 32'hAAAA_0001;
      tick();
      wrEn = 1'b0;
      tick();
      chk("rstmid_first_cs", 32'(shiftOutCS), 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         wrEn = 1'b1; wrData = 32'hBBBB_0000 + 32'(i);
         tick();
      end
      wrEn = 1'b0;
      for (int c = 0; c < 20 && !shiftOutCS; c++) tick();
      chk("rstmid_pre_cs", 32'(shiftOutCS), 32'd1);
      resetN = 1'b0;
      #1;
      chk("rstmid_cs",   32'(shiftOutCS), 32'd0);
      chk("rstmid_data", shiftOutData,    32'd0);
      chk("rstmid_sent", 32'(sentCount),  32'd0);
      chk("rstmid_busy", 32'(busy),       32'd0);
      chk("rstmid_ovf",  32'(overflow),   32'd0);
      @(negedge clk);
      resetN = 1'b1;
      extra = 0;
      repeat (30) begin
         tick();
         if (shiftOutCS) extra++;
      end
      chk("rstmid_no_strobe", 32'(extra), 32'd0);
      chk("rstmid_sent_after", 32'(sentCount), 32'd0);

      // Write accepted on the very first edge after reset release.
      resetN = 1'b0;
      #2;
      @(negedge clk);
      resetN = 1'b1;
      wrEn = 1'b1; wrData = 32'h0BAD_F00D;
      tick();
      wrEn = 1'b0;
      chk("first_edge_busy", 32'(busy), 32'd1);
      chk("first_edge_cs0", 32'(shiftOutCS), 32'd0);
      tick();
      chk("first_edge_cs1", 32'(shiftOutCS), 32'd1);
      chk("first_edge_data", shiftOutData, 32'h0BAD_F00D);

      // 257 words streamed with full respected: order kept, sentCount wraps to 1.
      resetN = 1'b0;
      #2;
      @(negedge clk);
      resetN = 1'b1;
      wi = 0;
      ri = 0;
      for (int c = 0; c < 4000 && ri < 257; c++) begin
         wrEn   = (wi < 257) && !full;
         wrData = 32'hA500_0000 + 32'(wi);
         if (wrEn) wi++;
         tick();
         wrEn = 1'b0;
         if (shiftOutCS) begin
            chk("wrap_data", shiftOutData, 32'hA500_0000 + 32'(ri));
            ri++;
         end
      end
      chk("wrap_count", 32'(ri), 32'd257);
      chk("wrap_sent", 32'(sentCount), 32'd1);
      chk("wrap_ovf", 32'(overflow), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
